fft_peak_detect: RTL and testbench
==================================

Name: fft_peak_detect

Overview:
- Sits directly downstream of the fft block. Consumes the completed spectrum through the fft's read port: `add_rd` is the address out, `dout` is the data in.
- On each `fft_done` pulse it scans the positive-frequency bins and finds the dominant bin by magnitude.
- Tracks how many consecutive frames that bin has persisted.
- Drives `note`/`duration` for the spi block.

Parameters:
- BIT_WIDTH, 16, width of each real/imag component.
- N, 9, log2 of FFT size; address width.
- FFT_SIZE, 512, number of FFT points (= 2**N).
- DUR_W, 8, width of the duration counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fft_done  in  1  one-cycle pulse: FFT output memory is valid
- fft_dout  in  2*BIT_WIDTH  FFT bin data; [2*BIT_WIDTH-1:BIT_WIDTH]=real, [BIT_WIDTH-1:0]=imag, signed two's complement; valid 1 cycle after add_rd
- threshold  in  2*BIT_WIDTH+1  minimum magnitude for a valid note; sampled at start of scan
- add_rd  out  N  FFT output read address
- busy  out  1  high while scanning or reporting
- peak_valid  out  1  one-cycle pulse: note/peak_mag/duration updated
- note  out  N  dominant bin index
- peak_mag  out  2*BIT_WIDTH+1  magnitude of dominant bin
- note_on  out  1  peak_mag >= threshold for last frame
- duration  out  DUR_W  consecutive frames with same note_on bin
- overrun  out  1  sticky: fft_done arrived while busy

Behaviour:
- Reset (sync, active-high, clk edge): all outputs 0, FSM to IDLE, stored previous bin 0, threshold register 0. Reset mid-scan aborts immediately; no peak_valid is produced.
- FSM states: IDLE, SCAN, DRAIN, REPORT.
- IDLE:
  - add_rd=0, busy=0.
  - On fft_done: latch threshold, clear running max (mag 0, bin 0), go to SCAN.
- SCAN:
  - add_rd steps 1,2,...,FFT_SIZE/2-1, one per cycle. DC bin 0 and negative frequencies are never read.
  - Each cycle, the data returned for the previous address is compared against the running max.
  - After issuing FFT_SIZE/2-1, go to DRAIN.
- DRAIN: compare the final returned bin, then go to REPORT.
- REPORT:
  - Register note, peak_mag and note_on.
  - Update duration.
  - Pulse peak_valid for exactly one cycle.
  - Return to IDLE.
- Timing: with the fft_done cycle numbered 0, add_rd=1 at cycle 1 and peak_valid high at cycle FFT_SIZE/2+1 (257 for defaults). busy is high in cycles 1..FFT_SIZE/2+1.
- Magnitude (default): |re|+|im|, zero-extended to 2*BIT_WIDTH+1.
  - abs of the most negative value saturates to 2**(BIT_WIDTH-1)-1.
- Comparison is strictly greater-than, so ties keep the lowest bin.
- All-zero spectrum: note=0, peak_mag=0, note_on=(threshold==0).
- note_on = peak_mag >= threshold.
- duration:
  - note_on=0: duration=0.
  - note_on=1 and note equals the stored previous bin and previous note_on=1: duration+1, saturating at all-ones.
  - Otherwise: duration=1.
  - The stored previous bin updates every REPORT.
- fft_done while busy: ignored, scan continues unchanged, overrun set (cleared only by reset).
- fft_done in the same cycle as REPORT: also counts as busy → overrun.
- note, peak_mag, note_on and duration hold their values between reports.

Optional Feature:
- Macro: FFT_PEAK_MAG_SQUARED_EN.
- Defined: magnitude = re*re + im*im, full width 2*BIT_WIDTH+1, unsigned, no truncation. A one-stage multiply pipeline adds 1 cycle, so DRAIN lasts 2 cycles and peak_valid arrives at cycle FFT_SIZE/2+2.
- Undefined: the L1 magnitude described above, with no multipliers inferred.

Test Plan:
- Reset mid-scan: pulse fft_done, assert reset at cycle 50 → peak_valid never pulses; all outputs 0; busy=0 the next cycle.
- Single tone: bin 37 = (re=1000, im=-500), all other bins 0, threshold=100 → peak_valid at cycle 257; note=37, peak_mag=1500, note_on=1, duration=1; add_rd sequence 1..255 observed.
- Ties and DC: bins 0, 20 and 40 all (300,0) → note=20 (DC ignored, lowest bin wins tie); peak_mag=300. Bin 255 = (-32768,0) alone → peak_mag=32767.
- Persistence: three consecutive frames peaking at bin 12 above threshold → duration 1,2,3. A fourth frame peaking at bin 13 → duration=1. A fifth frame below threshold → note_on=0, duration=0. Saturation check: DUR_W=2 with 5 repeats → duration holds 3.
- Overrun: second fft_done at cycle 100 of a scan → first report still at cycle 257 with correct data; overrun=1 until reset; no second scan starts.
- FFT_PEAK_MAG_SQUARED_EN defined: bin 37 = (1000,-500) → peak_mag=1250000; peak_valid at cycle 258.

Source files
------------

// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - dominant positive-frequency bin finder with note persistence tracking
// Optional build macro FFT_PEAK_MAG_SQUARED_EN: magnitude re*re+im*im with one extra pipeline cycle.
module fft_peak_detect #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int FFT_SIZE  = 512,
    parameter int DUR_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    input  logic [2*BIT_WIDTH-1:0] fft_dout,
    input  logic [2*BIT_WIDTH:0]   threshold,
    output logic [N-1:0]           add_rd,
    output logic                   busy,
    output logic                   peak_valid,
    output logic [N-1:0]           note,
    output logic [2*BIT_WIDTH:0]   peak_mag,
    output logic                   note_on,
    output logic [DUR_W-1:0]       duration,
    output logic                   overrun
);
    localparam int MW = 2*BIT_WIDTH+1;
    localparam logic [N-1:0] LAST_ADDR = N'(FFT_SIZE/2 - 1);
`ifdef FFT_PEAK_MAG_SQUARED_EN
    localparam logic DRAIN_LAST = 1'b1;
`else
    localparam logic DRAIN_LAST = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

    state_t                 state, state_nxt;
    logic                   drain_cnt;
    logic                   rd_vld, mag_vld;
    logic [N-1:0]           rd_addr, mag_bin, max_bin, cand_bin;
    logic [MW-1:0]          mag, max_mag, cand_mag, thr_q;
    logic                   final_on;
    logic [DUR_W-1:0]       final_dur;
    logic signed [BIT_WIDTH-1:0] re, im;

    assign re   = fft_dout[2*BIT_WIDTH-1:BIT_WIDTH];
    assign im   = fft_dout[BIT_WIDTH-1:0];
    assign busy = (state != IDLE);

    // Read data returns one cycle after the address, so tag it with the address that fetched it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld  <= 1'b0;
            rd_addr <= '0;
        end else begin
            rd_vld  <= (state == SCAN);
            rd_addr <= add_rd;
        end
    end

`ifdef FFT_PEAK_MAG_SQUARED_EN
    logic signed [2*BIT_WIDTH-1:0] re_x, im_x, re_sq, im_sq;
    assign re_x  = $signed({{BIT_WIDTH{re[BIT_WIDTH-1]}}, re});
    assign im_x  = $signed({{BIT_WIDTH{im[BIT_WIDTH-1]}}, im});
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            mag     <= '0;
            mag_vld <= 1'b0;
            mag_bin <= '0;
        end else begin
            mag     <= {1'b0, re_sq} + {1'b0, im_sq};
            mag_vld <= rd_vld;
            mag_bin <= rd_addr;
        end
    end
`else
    logic [BIT_WIDTH-1:0] re_abs, im_abs;

    // The most negative value has no positive twin; clamp it to the largest positive value.
    function automatic logic [BIT_WIDTH-1:0] sat_abs(input logic [BIT_WIDTH-1:0] v);
        if (v == {1'b1, {(BIT_WIDTH-1){1'b0}}})
            return {1'b0, {(BIT_WIDTH-1){1'b1}}};
        else if (v[BIT_WIDTH-1])
            return (~v) + 1'b1;
        else
            return v;
    endfunction

    assign re_abs  = sat_abs(re);
    assign im_abs  = sat_abs(im);
    assign mag     = {{(BIT_WIDTH+1){1'b0}}, re_abs} + {{(BIT_WIDTH+1){1'b0}}, im_abs};
    assign mag_vld = rd_vld;
    assign mag_bin = rd_addr;
`endif

    always_comb begin
        cand_mag = max_mag;
        cand_bin = max_bin;
        if (mag_vld && (mag > max_mag)) begin
            cand_mag = mag;
            cand_bin = mag_bin;
        end
    end

    assign final_on = (cand_mag >= thr_q);

    // note/note_on still hold the previous report, so they double as the persistence history.
    always_comb begin
        final_dur = '0;
        if (final_on) begin
            if ((cand_bin == note) && note_on)
                final_dur = (duration == {DUR_W{1'b1}}) ? duration : duration + 1'b1;
            else
                final_dur = DUR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fft_done) state_nxt = SCAN;
            SCAN:    if (add_rd == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            add_rd     <= '0;
            drain_cnt  <= 1'b0;
            thr_q      <= '0;
            max_mag    <= '0;
            max_bin    <= '0;
            peak_valid <= 1'b0;
            note       <= '0;
            peak_mag   <= '0;
            note_on    <= 1'b0;
            duration   <= '0;
            overrun    <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            if (fft_done && (state != IDLE))
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    add_rd    <= '0;
                    drain_cnt <= 1'b0;
                    if (fft_done) begin
                        thr_q   <= threshold;
                        max_mag <= '0;
                        max_bin <= '0;
                        add_rd  <= N'(1);
                    end
                end
                SCAN: begin
                    max_mag <= cand_mag;
                    max_bin <= cand_bin;
                    add_rd  <= (add_rd == LAST_ADDR) ? '0 : add_rd + 1'b1;
                end
                DRAIN: begin
                    max_mag   <= cand_mag;
                    max_bin   <= cand_bin;
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt == DRAIN_LAST) begin
                        note       <= cand_bin;
                        peak_mag   <= cand_mag;
                        note_on    <= final_on;
                        duration   <= final_dur;
                        peak_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb/tb_fft_peak_detect.sv - scoreboard bench for fft_peak_detect with directed spectra
module tb_fft_peak_detect;
    localparam int HALF = 256;
`ifdef FFT_PEAK_MAG_SQUARED_EN
    localparam int LAT = 258;
    localparam logic [32:0] M_TONE = 33'd1250000, M_TIE = 33'd90000, M_NEG = 33'd1073741824;
    localparam logic [32:0] M_MIX = 33'd74, M_P = 33'd250000, M_LOW = 33'd100;
`else
    localparam int LAT = 257;
    localparam logic [32:0] M_TONE = 33'd1500, M_TIE = 33'd300, M_NEG = 33'd32767;
    localparam logic [32:0] M_MIX = 33'd12, M_P = 33'd500, M_LOW = 33'd10;
`endif

    logic        clk = 0, reset = 1, fft_done = 0;
    logic [31:0] fft_dout = '0;
    logic [32:0] threshold = '0;
    logic [8:0]  add_rd, note, add_rd_2, note_2;
    logic        busy, peak_valid, note_on, overrun;
    logic        busy_2, peak_valid_2, note_on_2, overrun_2;
    logic [32:0] peak_mag, peak_mag_2;
    logic [7:0]  duration;
    logic [1:0]  duration_2;

    logic [31:0] mem [0:511];
    int cyc = 0, n_chk = 0, n_fail = 0;

    typedef struct {
        int          note;
        logic [32:0] mag;
        bit          on;
        int          dur;
        int          dur2;
        bit          ovr;
        int          cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t me;

    fft_peak_detect dut (
        .clk(clk), .reset(reset), .fft_done(fft_done), .fft_dout(fft_dout), .threshold(threshold),
        .add_rd(add_rd), .busy(busy), .peak_valid(peak_valid), .note(note), .peak_mag(peak_mag),
        .note_on(note_on), .duration(duration), .overrun(overrun)
    );

    fft_peak_detect #(.DUR_W(2)) dut2 (
        .clk(clk), .reset(reset), .fft_done(fft_done), .fft_dout(fft_dout), .threshold(threshold),
        .add_rd(add_rd_2), .busy(busy_2), .peak_valid(peak_valid_2), .note(note_2),
        .peak_mag(peak_mag_2), .note_on(note_on_2), .duration(duration_2), .overrun(overrun_2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) fft_dout <= mem[add_rd];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (peak_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_peak_valid", 1, 0);
            end else begin
                me = sbq.pop_front();
                check("report_cycle", cyc, me.cyc);
                check("note", note, me.note);
                check("peak_mag", peak_mag, me.mag);
                check("note_on", note_on, me.on);
                check("duration", duration, me.dur);
                check("overrun_at_report", overrun, me.ovr);
                check("dur2_peak_valid", peak_valid_2, 1);
                check("dur2_duration", duration_2, me.dur2);
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = '0;
    endtask

    task automatic set_bin(input int idx, input int re, input int im);
        mem[idx] = {16'(re), 16'(im)};
    endtask

    task automatic run_frame(input logic [32:0] thr, input int e_note, input logic [32:0] e_mag,
                             input bit e_on, input int e_dur, input int e_dur2, input bit e_ovr,
                             input int ovr_at);
        exp_t e;
        int bad;
        @(posedge clk); #1;
        threshold = thr;
        fft_done  = 1;
        e.note = e_note; e.mag = e_mag; e.on = e_on; e.dur = e_dur;
        e.dur2 = e_dur2; e.ovr = e_ovr; e.cyc = cyc + LAT;
        sbq.push_back(e);
        @(posedge clk); #1;
        fft_done  = 0;
        threshold = '1;
        bad = 0;
        for (int k = 1; k <= HALF + 4; k++) begin
            @(negedge clk);
            if (k <= HALF - 1 && add_rd !== 9'(k)) bad++;
            if (k <= LAT && busy !== 1'b1) bad++;
            if (k > LAT && busy !== 1'b0) bad++;
            @(posedge clk); #1;
            fft_done = (k + 1 == ovr_at);
        end
        fft_done = 0;
        check("addr_busy_sequence_errors", bad, 0);
    endtask

    initial begin
        clear_mem();
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset_add_rd", add_rd, 0);
        check("reset_busy", busy, 0);
        check("reset_peak_valid", peak_valid, 0);
        check("reset_outputs", {note, peak_mag, note_on, duration, overrun}, 0);

        clear_mem(); set_bin(37, 1000, -500);
        run_frame(33'd100, 37, M_TONE, 1, 1, 1, 0, 0);
        clear_mem(); set_bin(0, 300, 0); set_bin(20, 300, 0); set_bin(40, 300, 0);
        run_frame(33'd100, 20, M_TIE, 1, 1, 1, 0, 0);
        clear_mem(); set_bin(255, -32768, 0);
        run_frame(33'd100, 255, M_NEG, 1, 1, 1, 0, 0);
        clear_mem(); set_bin(100, -5, -7);
        run_frame(33'd0, 100, M_MIX, 1, 1, 1, 0, 0);
        clear_mem();
        run_frame(33'd0, 0, 33'd0, 1, 1, 1, 0, 0);
        run_frame(33'd5, 0, 33'd0, 0, 0, 0, 0, 0);

        clear_mem(); set_bin(12, 500, 0);
        for (int r = 1; r <= 5; r++)
            run_frame(33'd100, 12, M_P, 1, r, (r > 3) ? 3 : r, 0, 0);
        clear_mem(); set_bin(13, 500, 0);
        run_frame(33'd100, 13, M_P, 1, 1, 1, 0, 0);
        clear_mem(); set_bin(5, 10, 0);
        run_frame(33'd200, 5, M_LOW, 0, 0, 0, 0, 0);

        // Abort a scan with reset at cycle 50; no report may follow.
        clear_mem(); set_bin(37, 1000, -500);
        @(posedge clk); #1;
        threshold = 33'd100; fft_done = 1;
        @(posedge clk); #1;
        fft_done = 0;
        repeat (49) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("midscan_reset_busy", busy, 0);
        check("midscan_reset_add_rd", add_rd, 0);
        check("midscan_reset_outputs", {note, peak_mag, note_on, duration, overrun}, 0);
        repeat (300) @(posedge clk);

        run_frame(33'd100, 37, M_TONE, 1, 1, 1, 1, 100);
        @(negedge clk);
        check("overrun_no_second_scan", busy, 0);
        check("overrun_sticky", overrun, 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("overrun_still_idle", {busy, add_rd}, 0);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("overrun_cleared_by_reset", overrun, 0);

        check("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
